// File: rtl/rs_alu_station.sv
// rtl/rs_alu_station.sv - six-entry ALU reservation station with dual-CDB wakeup and lowest-index select
module rs_alu_station #(
    parameter int RS_SIZE = 6,
    parameter int IDX_W   = 3,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic [RS_SIZE-1:0] free_status,
    input  logic               disp_en,
    input  logic [IDX_W-1:0]   disp_idx,
    input  logic [OP_W-1:0]    disp_op,
    input  logic [DATA_W-1:0]  disp_pc,
    input  logic [TAG_W-1:0]   disp_dest,
    input  logic               disp_s1_rdy,
    input  logic               disp_s2_rdy,
    input  logic [DATA_W-1:0]  disp_s1_val,
    input  logic [DATA_W-1:0]  disp_s2_val,
    input  logic [TAG_W-1:0]   disp_s1_tag,
    input  logic [TAG_W-1:0]   disp_s2_tag,
    input  logic               cdb_alu_en,
    input  logic               cdb_ls_en,
    input  logic [TAG_W-1:0]   cdb_alu_tag,
    input  logic [TAG_W-1:0]   cdb_ls_tag,
    input  logic [DATA_W-1:0]  cdb_alu_data,
    input  logic [DATA_W-1:0]  cdb_ls_data,
    output logic               iss_valid,
    output logic [OP_W-1:0]    iss_op,
    output logic [DATA_W-1:0]  iss_a,
    output logic [DATA_W-1:0]  iss_b,
    output logic [TAG_W-1:0]   iss_dest,
    output logic [DATA_W-1:0]  iss_pc
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [OP_W-1:0]    op_q     [RS_SIZE];
    logic [OP_W-1:0]    op_d     [RS_SIZE];
    logic [DATA_W-1:0]  pc_q     [RS_SIZE];
    logic [DATA_W-1:0]  pc_d     [RS_SIZE];
    logic [TAG_W-1:0]   dest_q   [RS_SIZE];
    logic [TAG_W-1:0]   dest_d   [RS_SIZE];
    logic [TAG_W-1:0]   s1_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   s1_tag_d [RS_SIZE];
    logic [TAG_W-1:0]   s2_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   s2_tag_d [RS_SIZE];
    logic [DATA_W-1:0]  s1_val_q [RS_SIZE];
    logic [DATA_W-1:0]  s1_val_d [RS_SIZE];
    logic [DATA_W-1:0]  s2_val_q [RS_SIZE];
    logic [DATA_W-1:0]  s2_val_d [RS_SIZE];

    logic               iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]    iss_op_q, iss_op_d;
    logic [DATA_W-1:0]  iss_a_q, iss_a_d, iss_b_q, iss_b_d, iss_pc_q, iss_pc_d;
    logic [TAG_W-1:0]   iss_dest_q, iss_dest_d;

    logic [RS_SIZE-1:0] ready, sel_oh;

    // Operand capture from the CDBs; the ALU bus wins when both carry the tag.
    function automatic logic [DATA_W:0] snoop(input logic rdy, input logic [TAG_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        if (rdy)                                 return {1'b1, val};
        else if (cdb_alu_en && cdb_alu_tag == tag) return {1'b1, cdb_alu_data};
        else if (cdb_ls_en && cdb_ls_tag == tag)   return {1'b1, cdb_ls_data};
        else                                     return {1'b0, val};
    endfunction

    // Select the lowest-index entry whose operands are both present (isolate lowest set bit).
    always_comb begin
        ready  = busy_q & s1_rdy_q & s2_rdy_q;
        sel_oh = ready & (~ready + RS_SIZE'(1));
    end

    // Next state: flush clears everything; otherwise issue, wakeup and dispatch act together.
    always_comb begin
        busy_d      = busy_q;
        s1_rdy_d    = s1_rdy_q;
        s2_rdy_d    = s2_rdy_q;
        op_d        = op_q;
        pc_d        = pc_q;
        dest_d      = dest_q;
        s1_tag_d    = s1_tag_q;
        s2_tag_d    = s2_tag_q;
        s1_val_d    = s1_val_q;
        s2_val_d    = s2_val_q;
        iss_valid_d = 1'b0;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_dest_d  = iss_dest_q;
        iss_pc_d    = iss_pc_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    {s1_rdy_d[i], s1_val_d[i]} = snoop(s1_rdy_q[i], s1_tag_q[i], s1_val_q[i]);
                    {s2_rdy_d[i], s2_val_d[i]} = snoop(s2_rdy_q[i], s2_tag_q[i], s2_val_q[i]);
                end
                if (sel_oh[i]) begin
                    busy_d[i]   = 1'b0;
                    iss_valid_d = 1'b1;
                    iss_op_d    = op_q[i];
                    iss_a_d     = s1_val_q[i];
                    iss_b_d     = s2_val_q[i];
                    iss_dest_d  = dest_q[i];
                    iss_pc_d    = pc_q[i];
                end
                // Out-of-range indices (including the no-free code) never match any entry.
                if (disp_en && disp_idx == IDX_W'(i) && !busy_q[i]) begin
                    busy_d[i]   = 1'b1;
                    op_d[i]     = disp_op;
                    pc_d[i]     = disp_pc;
                    dest_d[i]   = disp_dest;
                    s1_tag_d[i] = disp_s1_tag;
                    s2_tag_d[i] = disp_s2_tag;
                    {s1_rdy_d[i], s1_val_d[i]} = snoop(disp_s1_rdy, disp_s1_tag, disp_s1_val);
                    {s2_rdy_d[i], s2_val_d[i]} = snoop(disp_s2_rdy, disp_s2_tag, disp_s2_val);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]     <= '0;
                pc_q[i]     <= '0;
                dest_q[i]   <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_dest_q  <= '0;
            iss_pc_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            dest_q      <= dest_d;
            s1_tag_q    <= s1_tag_d;
            s2_tag_q    <= s2_tag_d;
            s1_val_q    <= s1_val_d;
            s2_val_q    <= s2_val_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_dest_q  <= iss_dest_d;
            iss_pc_q    <= iss_pc_d;
        end
    end

    assign free_status = ~busy_q;
    assign iss_valid   = iss_valid_q;
    assign iss_op      = iss_op_q;
    assign iss_a       = iss_a_q;
    assign iss_b       = iss_b_q;
    assign iss_dest    = iss_dest_q;
    assign iss_pc      = iss_pc_q;

endmodule

// File: tb/tb_rs_alu_station.sv
// tb/tb_rs_alu_station.sv - randomized and directed bench for rs_alu_station with behavioural model
module tb_rs_alu_station;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic [5:0]  free_status;
    logic        disp_en;
    logic [2:0]  disp_idx;
    logic [5:0]  disp_op;
    logic [31:0] disp_pc;
    logic [3:0]  disp_dest;
    logic        disp_s1_rdy, disp_s2_rdy;
    logic [31:0] disp_s1_val, disp_s2_val;
    logic [3:0]  disp_s1_tag, disp_s2_tag;
    logic        cdb_alu_en, cdb_ls_en;
    logic [3:0]  cdb_alu_tag, cdb_ls_tag;
    logic [31:0] cdb_alu_data, cdb_ls_data;
    logic        iss_valid;
    logic [5:0]  iss_op;
    logic [31:0] iss_a, iss_b, iss_pc;
    logic [3:0]  iss_dest;

    int n_chk = 0;
    int n_err = 0;

    rs_alu_station dut (
        .clk(clk), .rst(rst), .flush(flush), .free_status(free_status),
        .disp_en(disp_en), .disp_idx(disp_idx), .disp_op(disp_op), .disp_pc(disp_pc),
        .disp_dest(disp_dest), .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
        .disp_s1_val(disp_s1_val), .disp_s2_val(disp_s2_val),
        .disp_s1_tag(disp_s1_tag), .disp_s2_tag(disp_s2_tag),
        .cdb_alu_en(cdb_alu_en), .cdb_ls_en(cdb_ls_en),
        .cdb_alu_tag(cdb_alu_tag), .cdb_ls_tag(cdb_ls_tag),
        .cdb_alu_data(cdb_alu_data), .cdb_ls_data(cdb_ls_data),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
        .iss_dest(iss_dest), .iss_pc(iss_pc)
    );

    always #5 clk = ~clk;

    // Behavioural model: a table of instruction records plus the last issued record.
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [31:0] pc;
        bit [3:0]  dest;
        bit        r1, r2;
        bit [3:0]  t1, t2;
        bit [31:0] v1, v2;
    } ent_t;

    ent_t      m [6];
    ent_t      snap [6];
    bit        m_iv;
    bit [5:0]  m_op;
    bit [31:0] m_a, m_b, m_pc;
    bit [3:0]  m_dest;
    int        pick;

    function automatic bit [32:0] resolve(bit r, bit [3:0] t, bit [31:0] v);
        if (r) return {1'b1, v};
        if (cdb_alu_en && cdb_alu_tag == t) return {1'b1, cdb_alu_data};
        if (cdb_ls_en && cdb_ls_tag == t) return {1'b1, cdb_ls_data};
        return {1'b0, v};
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < 6; i++) if (!m[i].busy) return i;
        return 7;
    endfunction

    // Model update at every clock edge, and immediately on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) m[i] = '{default: 0};
            m_iv = 0; m_op = 0; m_a = 0; m_b = 0; m_pc = 0; m_dest = 0;
        end else if (flush) begin
            for (int i = 0; i < 6; i++) m[i].busy = 0;
            m_iv = 0;
        end else begin
            snap = m;
            pick = -1;
            for (int i = 5; i >= 0; i--)
                if (snap[i].busy && snap[i].r1 && snap[i].r2) pick = i;
            m_iv = (pick >= 0);
            if (pick >= 0) begin
                m_op = snap[pick].op; m_a = snap[pick].v1; m_b = snap[pick].v2;
                m_dest = snap[pick].dest; m_pc = snap[pick].pc;
                m[pick].busy = 0;
            end
            for (int i = 0; i < 6; i++) if (snap[i].busy && i != pick) begin
                {m[i].r1, m[i].v1} = resolve(snap[i].r1, snap[i].t1, snap[i].v1);
                {m[i].r2, m[i].v2} = resolve(snap[i].r2, snap[i].t2, snap[i].v2);
            end
            if (disp_en && disp_idx < 6 && !snap[disp_idx].busy) begin
                m[disp_idx].busy = 1; m[disp_idx].op = disp_op; m[disp_idx].pc = disp_pc;
                m[disp_idx].dest = disp_dest; m[disp_idx].t1 = disp_s1_tag; m[disp_idx].t2 = disp_s2_tag;
                {m[disp_idx].r1, m[disp_idx].v1} = resolve(disp_s1_rdy, disp_s1_tag, disp_s1_val);
                {m[disp_idx].r2, m[disp_idx].v2} = resolve(disp_s2_rdy, disp_s2_tag, disp_s2_val);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        bit [5:0] exp_free;
        for (int i = 0; i < 6; i++) exp_free[i] = !m[i].busy;
        chk("free_status", 32'(free_status), 32'(exp_free));
        chk("iss_valid", 32'(iss_valid), 32'(m_iv));
        chk("iss_op", 32'(iss_op), 32'(m_op));
        chk("iss_a", iss_a, m_a);
        chk("iss_b", iss_b, m_b);
        chk("iss_dest", 32'(iss_dest), 32'(m_dest));
        chk("iss_pc", iss_pc, m_pc);
    end

    task automatic idle();
        flush = 0; disp_en = 0; disp_idx = 0; disp_op = 0; disp_pc = 0; disp_dest = 0;
        disp_s1_rdy = 0; disp_s2_rdy = 0; disp_s1_val = 0; disp_s2_val = 0;
        disp_s1_tag = 0; disp_s2_tag = 0;
        cdb_alu_en = 0; cdb_ls_en = 0; cdb_alu_tag = 0; cdb_ls_tag = 0;
        cdb_alu_data = 0; cdb_ls_data = 0;
    endtask

    task automatic disp(input int idx, input bit [5:0] op, input bit [3:0] dest,
                        input bit r1, input bit [31:0] v1, input bit [3:0] t1,
                        input bit r2, input bit [31:0] v2, input bit [3:0] t2);
        disp_en = 1; disp_idx = 3'(idx); disp_op = op; disp_pc = 32'h1000 + 32'(idx * 4);
        disp_dest = dest; disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
        disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        idle();
        step(); step();
        chk("reset_free", 32'(free_status), 32'h3f);
        chk("reset_iss_valid", 32'(iss_valid), 0);
        rst = 0;

        // Ready dispatch issues one edge later.
        disp(0, 6'h01, 4'h3, 1, 5, 0, 1, 7, 0); step();
        chk("disp_busy0", 32'(free_status), 32'h3e);
        idle(); step();
        chk("ready_valid", 32'(iss_valid), 1);
        chk("ready_a", iss_a, 5);
        chk("ready_b", iss_b, 7);
        chk("ready_dest", 32'(iss_dest), 3);
        chk("ready_freed", 32'(free_status), 32'h3f);

        // Wakeup from the LS bus.
        disp(2, 6'h02, 4'h4, 0, 0, 4'h9, 1, 1, 0); step();
        idle(); cdb_ls_en = 1; cdb_ls_tag = 4'h9; cdb_ls_data = 32'hDEAD; step();
        chk("wake_not_yet", 32'(iss_valid), 0);
        idle(); step();
        chk("wake_valid", 32'(iss_valid), 1);
        chk("wake_a", iss_a, 32'hDEAD);
        chk("wake_freed", 32'(free_status), 32'h3f);

        // Both buses carry the same tag: ALU data wins.
        disp(0, 6'h03, 4'h5, 0, 0, 4'h5, 1, 0, 0); step();
        idle(); cdb_alu_en = 1; cdb_alu_tag = 4'h5; cdb_alu_data = 1;
        cdb_ls_en = 1; cdb_ls_tag = 4'h5; cdb_ls_data = 2; step();
        idle(); step();
        chk("dual_a", iss_a, 1);

        // Dispatch-cycle bypass from the ALU bus.
        disp(0, 6'h04, 4'h6, 0, 0, 4'h7, 1, 3, 0);
        cdb_alu_en = 1; cdb_alu_tag = 4'h7; cdb_alu_data = 32'h77; step();
        idle(); step();
        chk("bypass_valid", 32'(iss_valid), 1);
        chk("bypass_a", iss_a, 32'h77);

        // Lowest-index priority over entries 1, 3, 5.
        disp(5, 6'h05, 4'h5, 0, 0, 4'hA, 1, 5, 0); step();
        disp(3, 6'h05, 4'h3, 0, 0, 4'hA, 1, 3, 0); step();
        disp(1, 6'h05, 4'h1, 0, 0, 4'hA, 1, 1, 0); step();
        idle(); cdb_alu_en = 1; cdb_alu_tag = 4'hA; cdb_alu_data = 32'h100; step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("prio_valid", 32'(iss_valid), 1);
            chk("prio_b", iss_b, 32'(2 * k + 1));
        end
        step();
        chk("prio_done", 32'(iss_valid), 0);

        // Fill every entry, then try invalid and busy-target dispatches.
        for (int i = 0; i < 6; i++) begin
            disp(i, 6'h06, 4'(i), 0, 0, 4'hF, 1, 32'h10 + 32'(i), 0); step();
        end
        chk("full_free", 32'(free_status), 0);
        disp(7, 6'h07, 4'h1, 1, 1, 0, 1, 1, 0); step();
        chk("full_idx7", 32'(free_status), 0);
        disp(6, 6'h07, 4'h1, 1, 1, 0, 1, 1, 0); step();
        chk("full_idx6", 32'(free_status), 0);
        disp(2, 6'h07, 4'h1, 1, 1, 0, 1, 32'hBAD, 0); step();
        chk("full_busy", 32'(iss_valid), 0);
        idle(); cdb_ls_en = 1; cdb_ls_tag = 4'hF; cdb_ls_data = 32'h55; step();
        idle();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("drain_b", iss_b, 32'h10 + 32'(k));
        end

        // Flush beats a ready entry and a same-cycle dispatch.
        disp(0, 6'h08, 4'h2, 1, 1, 0, 1, 2, 0); step();
        disp(1, 6'h08, 4'h2, 1, 1, 0, 1, 2, 0); flush = 1; step();
        chk("flush_free", 32'(free_status), 32'h3f);
        chk("flush_valid", 32'(iss_valid), 0);
        idle(); step();
        chk("flush_nowrite", 32'(iss_valid), 0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            disp(i, 6'h09, 4'h1, 0, 0, 4'hE, 1, 1, 0); step();
        end
        idle();
        #2 rst = 1;
        #1;
        chk("arst_free", 32'(free_status), 32'h3f);
        chk("arst_valid", 32'(iss_valid), 0);
        chk("arst_a", iss_a, 0);
        step(); rst = 0;
        cdb_alu_en = 1; cdb_alu_tag = 4'hE; cdb_alu_data = 9; step();
        idle(); step();
        chk("arst_noissue", 32'(iss_valid), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 9) < 7) begin
                int idx;
                idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : lowest_free();
                disp(idx, 6'($urandom), 4'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 7)),
                     1'($urandom), $urandom, 4'($urandom_range(0, 7)));
                disp_pc = $urandom;
            end
            cdb_alu_en = 1'($urandom); cdb_alu_tag = 4'($urandom_range(0, 7)); cdb_alu_data = $urandom;
            cdb_ls_en = 1'($urandom); cdb_ls_tag = 4'($urandom_range(0, 7)); cdb_ls_data = $urandom;
            flush = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
